// File: rtl/ram_port_pkg.sv
// Shared types and helpers for the BRAM port initiator.
// Response tags, buffered response entries and the range check.
package ram_port_pkg;

   localparam int PKG_DATA_W = 32;
   localparam int PKG_ADDR_W = 32;

   typedef struct packed {
      logic valid;
      logic write;
      logic err;
   } rsp_tag_t;

   typedef struct packed {
      logic                  write;
      logic                  err;
      logic [PKG_DATA_W-1:0] rdata;
   } rsp_entry_t;

   function automatic logic addr_in_range(
      input logic [PKG_ADDR_W-1:0] addr,
      input logic [PKG_ADDR_W-1:0] size
   );
      return addr < size;
   endfunction

endpackage

// File: rtl/ram_port_rsp_fifo.sv
// First-word-fall-through response buffer.
// Head fields read as zero while the buffer is empty.
module ram_port_rsp_fifo
   import ram_port_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  rsp_entry_t    push_data,
   input  logic          pop,
   output rsp_entry_t    head,
   output logic          head_valid,
   output logic [CW-1:0] count
);

   rsp_entry_t    store [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop     = pop && (count != '0);
   assign head_valid = (count != '0);
   assign head       = head_valid ? store[rd_ptr] : '0;

   // Entry storage; a push while full lands on the slot being popped.
   always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= push_data;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (do_pop) rd_ptr <= nxt(rd_ptr);
         case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ram_port_master.sv
// Valid/ready initiator for one port of the dual-port BRAM.
// Issues requests, tracks read latency, buffers ordered responses.
module ram_port_master
   import ram_port_pkg::*;
#(
   parameter int          DATA_WIDTH   = 32,
   parameter int          ADDR_WIDTH   = 32,
   parameter logic [31:0] RAM_SIZE     = 32'h20,
   parameter int          READ_LATENCY = 2
) (
   input  logic                    clka,
   input  logic                    rsta_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic                    rsp_err,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    mem_en,
   output logic [DATA_WIDTH/8-1:0] mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_din,
   input  logic [DATA_WIDTH-1:0]   mem_dout
);

   localparam int FIFO_DEPTH = READ_LATENCY + 2;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic          accept;
   logic          in_range;
   rsp_tag_t      iss_tag;
   rsp_tag_t      tag_q [READ_LATENCY];
   rsp_tag_t      last;
   rsp_entry_t    push_data;
   rsp_entry_t    head;
   logic [CW-1:0] fifo_count;
   logic [7:0]    occ;

   assign in_range = addr_in_range(req_addr, PKG_ADDR_W'(RAM_SIZE));
   assign accept   = req_valid && req_ready;

   // Issue register: one-cycle BRAM strobe per in-range request.
   always_ff @(posedge clka) begin
      if (!rsta_n) begin
         mem_en   <= 1'b0;
         mem_we   <= '0;
         mem_addr <= '0;
         mem_din  <= '0;
         iss_tag  <= '0;
      end else begin
         mem_en  <= accept && in_range;
         mem_we  <= (accept && in_range && req_write) ? req_wstrb : '0;
         iss_tag <= '{valid: accept, write: req_write, err: !in_range};
         if (accept) begin
            mem_addr <= req_addr;
            mem_din  <= req_wdata;
         end
      end
   end

   // Tag pipe that tracks the BRAM read latency.
   always_ff @(posedge clka) begin
      if (!rsta_n) begin
         for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= iss_tag;
         for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign last            = tag_q[READ_LATENCY-1];
   assign push_data.write = last.write;
   assign push_data.err   = last.err;
   assign push_data.rdata = (!last.write && !last.err) ? mem_dout : '0;

   ram_port_rsp_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clka),
      .rst_n      (rsta_n),
      .push       (last.valid),
      .push_data  (push_data),
      .pop        (rsp_ready),
      .head       (head),
      .head_valid (rsp_valid),
      .count      (fifo_count)
   );

   assign rsp_write = head.write;
   assign rsp_err   = head.err;
   assign rsp_rdata = head.rdata;

   // Credit: every accepted but unreturned response holds a slot.
   always_comb begin
      occ = {7'd0, iss_tag.valid} + 8'(fifo_count);
      for (int i = 0; i < READ_LATENCY; i++) begin
         occ = occ + {7'd0, tag_q[i].valid};
      end
   end

   assign req_ready = rsta_n && (occ < 8'(FIFO_DEPTH));

endmodule

// File: tb/tb_ram_port_master.sv
// Randomised and directed bench for ram_port_master.
// Responses are predicted from a queue of accepted requests.
module tb_ram_port_master;

   localparam logic [31:0] RS = 32'h40;

   logic        clk;
   logic        rsta_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_write;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   ram_port_master #(
      .DATA_WIDTH   (32),
      .ADDR_WIDTH   (32),
      .RAM_SIZE     (RS),
      .READ_LATENCY (2)
   ) dut (
      .clka      (clk),
      .rsta_n    (rsta_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_write (rsp_write),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      logic        e;
      logic [31:0] d;
      int          avail;
   } exp_t;

   typedef struct {
      logic        w;
      logic        e;
      logic [31:0] d;
      int          seen;
   } obs_t;

   exp_t        q[$];
   obs_t        log_q[$];
   logic [31:0] shadow [16];
   logic [31:0] bram [16];
   logic [31:0] p1, p2;
   int          edges, checks, errors;
   logic        en_exp, after_rst, last_acc;
   logic [31:0] addr_exp, din_exp;
   logic [3:0]  we_exp;
   int          last_acc_edge;

   function automatic logic [31:0] merge(
      input logic [31:0] old, input logic [31:0] d, input logic [3:0] s
   );
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_outputs();
      logic mv;
      mv = 1'b0;
      if (q.size() > 0) mv = (q[0].avail <= edges);
      chk("req_ready", 32'(req_ready), 32'(rsta_n && q.size() < 4));
      chk("rsp_valid", 32'(rsp_valid), 32'(mv));
      if (mv) begin
         chk("rsp_write", 32'(rsp_write), 32'(q[0].w));
         chk("rsp_err", 32'(rsp_err), 32'(q[0].e));
         chk("rsp_rdata", rsp_rdata, q[0].d);
      end
      chk("mem_en", 32'(mem_en), 32'(en_exp));
      if (en_exp) begin
         chk("mem_addr", mem_addr, addr_exp);
         chk("mem_we", 32'(mem_we), 32'(we_exp));
         chk("mem_din", mem_din, din_exp);
      end else begin
         chk("mem_we_idle", 32'(mem_we), 32'd0);
      end
      if (after_rst) begin
         chk("rst_mem_addr", mem_addr, 32'd0);
         chk("rst_mem_din", mem_din, 32'd0);
         chk("rst_rsp_write", 32'(rsp_write), 32'd0);
         chk("rst_rsp_err", 32'(rsp_err), 32'd0);
         chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      end
   endtask

   task automatic cyc(input logic v, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic rr, input logic rn);
      logic mv, acc, inr;
      int   idx;
      @(negedge clk);
      check_outputs();
      mem_dout = p2;
      p2 = p1;
      if (mem_en) begin
         idx = int'(mem_addr[5:2]);
         p1 = bram[idx];
         bram[idx] = merge(bram[idx], mem_din, mem_we);
      end
      mv = 1'b0;
      if (q.size() > 0) mv = (q[0].avail <= edges);
      if (rsp_valid && rr && rn)
         log_q.push_back('{rsp_write, rsp_err, rsp_rdata, edges});
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_wstrb = s;
      rsp_ready = rr;
      rsta_n    = rn;
      acc = v && rn && (q.size() < 4);
      edges++;
      last_acc = acc;
      if (!rn) begin
         q.delete();
         en_exp    = 1'b0;
         after_rst = 1'b1;
      end else begin
         after_rst = 1'b0;
         if (mv && rr) void'(q.pop_front());
         inr    = a < RS;
         en_exp = acc && inr;
         we_exp = (acc && inr && w) ? s : 4'h0;
         if (acc) begin
            addr_exp      = a;
            din_exp       = d;
            last_acc_edge = edges;
            idx = int'(a[5:2]);
            q.push_back('{w, !inr, (!w && inr) ? shadow[idx] : 32'd0,
                          edges + 3});
            if (w && inr) shadow[idx] = merge(shadow[idx], d, s);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1, 1);
   endtask

   task automatic send(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
      int n;
      n = 0;
      do begin
         cyc(1, w, a, d, s, 1, 1);
         n++;
      end while (!last_acc && n < 20);
      chk("send_accepted", 32'(last_acc), 32'd1);
   endtask

   task automatic log_chk(input string name, input int i,
                          input logic w, input logic e,
                          input logic [31:0] d);
      if (log_q.size() > i) begin
         chk({name, "_write"}, 32'(log_q[i].w), 32'(w));
         chk({name, "_err"}, 32'(log_q[i].e), 32'(e));
         chk({name, "_rdata"}, log_q[i].d, d);
      end else begin
         chk({name, "_missing"}, 32'(log_q.size()), 32'(i + 1));
      end
   endtask

   initial begin
      int na, t0;
      checks = 0; errors = 0; edges = 0;
      en_exp = 1'b0; after_rst = 1'b1; last_acc = 1'b0;
      addr_exp = '0; din_exp = '0; we_exp = '0; last_acc_edge = 0;
      p1 = '0; p2 = '0; mem_dout = '0;
      for (int i = 0; i < 16; i++) begin
         shadow[i] = $urandom;
         bram[i]   = shadow[i];
      end
      rsta_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
      repeat (2) @(posedge clk);

      cyc(0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 1);
      #1 chk("ready_after_release", 32'(req_ready), 32'd1);
      idle(2);

      log_q.delete();
      send(1, 32'h00, 32'hcafecafe, 4'hf);
      send(1, 32'h1c, 32'h12345678, 4'hf);
      send(0, 32'h00, 32'h0, 4'h0);
      send(0, 32'h1c, 32'h0, 4'h0);
      idle(8);
      chk("basic_count", 32'(log_q.size()), 32'd4);
      log_chk("basic0", 0, 1, 0, 32'h0);
      log_chk("basic1", 1, 1, 0, 32'h0);
      log_chk("basic2", 2, 0, 0, 32'hcafecafe);
      log_chk("basic3", 3, 0, 0, 32'h12345678);

      log_q.delete();
      send(0, 32'h40, 32'h0, 4'h0);
      t0 = last_acc_edge;
      idle(6);
      log_chk("oor", 0, 0, 1, 32'h0);
      if (log_q.size() > 0)
         chk("oor_latency", 32'(log_q[0].seen - t0), 32'd3);

      for (int i = 0; i < 4; i++)
         send(1, 32'(4 * i), 32'h11110000 + 32'(i), 4'hf);
      idle(6);
      log_q.delete();
      na = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 32'(4 * i), 0, 0, 1, 1);
         na += int'(last_acc);
      end
      idle(8);
      chk("b2b_accepts", 32'(na), 32'd4);
      for (int i = 0; i < 4; i++) begin
         log_chk("b2b", i, 0, 0, 32'h11110000 + 32'(i));
         if (log_q.size() > i)
            chk("b2b_consecutive", 32'(log_q[i].seen - log_q[0].seen),
                32'(i));
      end

      log_q.delete();
      na = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1, 0, 32'(4 * (i % 4)), 0, 0, 0, 1);
         na += int'(last_acc);
      end
      chk("bp_accepts", 32'(na), 32'd4);
      #1 chk("bp_ready_low", 32'(req_ready), 32'd0);
      idle(10);
      chk("bp_count", 32'(log_q.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         log_chk("bp", i, 0, 0, 32'h11110000 + 32'(i));

      log_q.delete();
      send(1, 32'h04, 32'hffffffff, 4'hf);
      send(1, 32'h04, 32'h0000ab00, 4'b0010);
      send(0, 32'h04, 32'h0, 4'h0);
      idle(8);
      log_chk("strobe", 2, 0, 0, 32'hffffabff);

      log_q.delete();
      send(0, 32'h00, 32'h0, 4'h0);
      send(0, 32'h08, 32'h0, 4'h0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      idle(8);
      chk("rst_no_rsp", 32'(log_q.size()), 32'd0);
      send(0, 32'h0c, 32'h0, 4'h0);
      idle(6);
      log_chk("post_rst", 0, 0, 0, 32'h11110003);

      for (int i = 0; i < 600; i++) begin
         cyc(($urandom % 4) != 0, 1'($urandom), 32'(($urandom % 20) * 4),
             $urandom, 4'($urandom), ($urandom % 4) != 0,
             ($urandom % 150) != 0);
      end
      idle(12);
      chk("drained", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
